// File: rtl/bcd_square_seq.sv
// Sequential BCD squarer: 3-digit BCD root in, 6-digit BCD square out.
// The datapath works in three phases. CONV turns the BCD root into binary,
// MUL squares it with a shift-add multiplier, and BCD turns the product back
// into BCD with double-dabble. Results appear on out_dec only when done pulses.
module bcd_square_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] in_dec,
  output logic        ready,
  output logic        done,
  output logic [23:0] out_dec,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    MUL,
    BCD
  } state_t;

  // Each phase ends when the counter reaches its last value.
  localparam logic [4:0] CONV_LAST = 5'd2;
  localparam logic [4:0] MUL_LAST  = 5'd9;
  localparam logic [4:0] BCD_LAST  = 5'd19;

  state_t      state;
  state_t      state_next;

  logic [11:0] in_q;
  logic [4:0]  cnt;
  logic [9:0]  bin;
  logic [19:0] mcand;
  logic [9:0]  mplier;
  logic [19:0] acc;
  logic [19:0] sh;
  logic [23:0] bcd;
  logic        inv_pend;

  logic        in_bad;
  logic [9:0]  bin_next;
  logic [19:0] acc_next;
  logic [23:0] bcd_adj;
  logic [43:0] dd_shift;

  // A request is rejected when any of the three nibbles is not a decimal digit.
  always_comb begin
    in_bad = (in_dec[11:8] > 4'd9) || (in_dec[7:4] > 4'd9) || (in_dec[3:0] > 4'd9);
  end

  // Arithmetic for one step of each phase.
  // CONV: bin*10 + next digit, where bin*10 is computed as bin*8 + bin*2.
  // MUL: add the shifted multiplicand when the current multiplier bit is set.
  // BCD: add 3 to every nibble that is 5 or more, then shift the whole
  //      BCD:binary register left by one bit.
  always_comb begin
    bin_next = (bin << 3) + (bin << 1) + {6'd0, in_q[11:8]};
    acc_next = acc + (mplier[0] ? mcand : 20'd0);
    bcd_adj  = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj, sh} << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // A rejected request never leaves IDLE. Its done pulse is produced by the
  // inv_pend flag in the datapath instead.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !in_bad) state_next = CONV;
      CONV: if (cnt == CONV_LAST) state_next = MUL;
      MUL:  if (cnt == MUL_LAST)  state_next = BCD;
      BCD:  if (cnt == BCD_LAST)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  // ready is registered from the next state, so it is high in exactly the
  // cycles where the FSM sits in IDLE.
  // out_dec and err change only together with a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b1;
      done     <= 1'b0;
      out_dec  <= 24'h000000;
      err      <= 1'b0;
      in_q     <= 12'd0;
      cnt      <= 5'd0;
      bin      <= 10'd0;
      mcand    <= 20'd0;
      mplier   <= 10'd0;
      acc      <= 20'd0;
      sh       <= 20'd0;
      bcd      <= 24'd0;
      inv_pend <= 1'b0;
    end else begin
      ready    <= (state_next == IDLE);
      done     <= 1'b0;
      inv_pend <= 1'b0;
      if (inv_pend) begin
        done    <= 1'b1;
        err     <= 1'b1;
        out_dec <= 24'h000000;
      end
      case (state)
        IDLE: begin
          if (start) begin
            in_q     <= in_dec;
            cnt      <= 5'd0;
            bin      <= 10'd0;
            mcand    <= 20'd0;
            mplier   <= 10'd0;
            acc      <= 20'd0;
            sh       <= 20'd0;
            bcd      <= 24'd0;
            inv_pend <= in_bad;
          end
        end
        CONV: begin
          bin  <= bin_next;
          in_q <= in_q << 4;
          cnt  <= cnt + 5'd1;
          if (cnt == CONV_LAST) begin
            cnt    <= 5'd0;
            mcand  <= {10'd0, bin_next};
            mplier <= bin_next;
            acc    <= 20'd0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == MUL_LAST) begin
            cnt <= 5'd0;
            sh  <= acc_next;
            bcd <= 24'd0;
          end
        end
        BCD: begin
          bcd <= dd_shift[43:20];
          sh  <= dd_shift[19:0];
          cnt <= cnt + 5'd1;
          if (cnt == BCD_LAST) begin
            cnt     <= 5'd0;
            out_dec <= dd_shift[43:20];
            done    <= 1'b1;
            err     <= 1'b0;
          end
        end
        default: cnt <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_square_seq.sv
// Self-checking bench for bcd_square_seq.
// It runs directed cases with hand-computed results, then a randomized run.
// Both are checked every cycle against a reference model that computes the
// square arithmetically and times the result with a simple countdown.
module tb_bcd_square_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] in_dec;
  logic        ready;
  logic        done;
  logic [23:0] out_dec;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Reference model state.
  bit          m_ready;
  bit          m_done;
  bit          m_err;
  bit          m_inv_pend;
  logic [23:0] m_out;
  logic [23:0] m_pending;
  int          m_remain;

  bcd_square_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_dec  (in_dec),
    .ready   (ready),
    .done    (done),
    .out_dec (out_dec),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isBad(input logic [11:0] v);
    return (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
  endfunction

  // Decode the BCD root, square it with plain arithmetic, re-encode as BCD.
  function automatic logic [23:0] bcdSquare(input logic [11:0] v);
    int root;
    int sq;
    logic [23:0] r;
    root = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    sq = root * root;
    r = 24'd0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(sq % 10);
      sq = sq / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [11:0] v);
    start  = s;
    in_dec = v;
  endtask

  // Reference model.
  // An accepted valid request finishes 33 edges after it is sampled.
  // An invalid request reports one edge after it is sampled.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ready = 1; m_done = 0; m_err = 0; m_inv_pend = 0;
        m_out = 24'h000000; m_pending = 24'h000000; m_remain = 0;
      end else begin
        bit was_ready;
        was_ready = m_ready;
        m_done = 0;
        if (m_inv_pend) begin
          m_done = 1; m_err = 1; m_out = 24'h000000; m_inv_pend = 0;
        end
        if (m_remain > 0) begin
          m_remain--;
          if (m_remain == 0) begin
            m_done = 1; m_err = 0; m_out = m_pending; m_ready = 1;
          end
        end
        if (was_ready && start) begin
          if (isBad(in_dec)) begin
            m_inv_pend = 1;
          end else begin
            m_pending = bcdSquare(in_dec);
            m_remain = 33;
            m_ready = 0;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("ready", {23'd0, ready}, {23'd0, m_ready});
        checkOutput("done", {23'd0, done}, {23'd0, m_done});
        checkOutput("out_dec", out_dec, m_out);
        checkOutput("err", {23'd0, err}, {23'd0, m_err});
      end
    end
  end

  // Issue one request and wait for its done pulse, with a bounded wait.
  // If poke_at is non-negative, a 12'h777 start is pulsed that many cycles
  // into the operation; the DUT must ignore it.
  task automatic runOp(input string name, input logic [11:0] v, input logic [23:0] exp_out,
                       input logic exp_err, input int exp_cycles, input int poke_at);
    int cycles;
    bit seen;
    applyStimulus(1'b1, v);
    @(posedge clk);
    #2 applyStimulus(1'b0, 12'h000);
    cycles = 0;
    seen = 0;
    while (!seen && cycles < 60) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done) begin
        seen = 1;
      end else begin
        if (exp_cycles > 1) checkOutput({name, "_ready_busy"}, {23'd0, ready}, 24'd0);
        if (cycles == poke_at) #1 applyStimulus(1'b1, 12'h777);
        else if (cycles == poke_at + 1) #1 applyStimulus(1'b0, 12'h000);
      end
    end
    checkOutput({name, "_latency"}, 24'(cycles), 24'(exp_cycles));
    checkOutput({name, "_out"}, out_dec, exp_out);
    checkOutput({name, "_err"}, {23'd0, err}, {23'd0, exp_err});
    checkOutput({name, "_ready_done"}, {23'd0, ready}, 24'd1);
  endtask

  task automatic countDones(input string name, input int n);
    int dones;
    dones = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    checkOutput(name, 24'(dones), 24'd0);
  endtask

  // Main sequence: directed cases first, then the randomized run.
  initial begin
    applyStimulus(1'b0, 12'h000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1;
    checkOutput("reset_ready", {23'd0, ready}, 24'd1);
    checkOutput("reset_done", {23'd0, done}, 24'd0);
    checkOutput("reset_out", out_dec, 24'h000000);

    runOp("zero", 12'h000, 24'h000000, 1'b0, 33, -1);
    runOp("n999", 12'h999, 24'h998001, 1'b0, 33, -1);
    runOp("n123", 12'h123, 24'h015129, 1'b0, 33, -1);

    // Back-to-back: the second start is raised in the done cycle.
    runOp("b2b_4", 12'h004, 24'h000016, 1'b0, 33, -1);
    runOp("b2b_5", 12'h005, 24'h000025, 1'b0, 33, -1);

    runOp("inv_0A5", 12'h0A5, 24'h000000, 1'b1, 1, -1);
    runOp("after_inv", 12'h012, 24'h000144, 1'b0, 33, -1);

    runOp("ignore_777", 12'h321, 24'h103041, 1'b0, 33, 10);
    countDones("no_second_done", 40);

    // Asynchronous abort 15 cycles into an operation.
    applyStimulus(1'b1, 12'h123);
    @(posedge clk);
    #2 applyStimulus(1'b0, 12'h000);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", {23'd0, ready}, 24'd1);
    checkOutput("abort_done", {23'd0, done}, 24'd0);
    checkOutput("abort_out", out_dec, 24'h000000);
    checkOutput("abort_err", {23'd0, err}, 24'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    countDones("abort_no_done", 40);
    runOp("after_abort", 12'h500, 24'h250000, 1'b0, 33, -1);

    // Randomized traffic: sparse starts, about one in five non-BCD.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0)
          applyStimulus(1'b1, 12'($urandom));
        else
          applyStimulus(1'b1, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9))});
      end else begin
        applyStimulus(1'b0, 12'($urandom));
      end
    end
    @(posedge clk);
    #2 applyStimulus(1'b0, 12'h000);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
